// File: rtl/marquee_pkg.sv
// Shared constants for the 12-LED marquee: speed encoding and default timing
// used by the step controller, sequencer and board top.
package marquee_pkg;
    localparam int SPEED_W      = 2;
    localparam int SPEED_LEVELS = 4;

    // 2 Hz base step rate and 20 ms debounce window at a 50 MHz board clock
    localparam int BASE_PERIOD_DEFAULT     = 25_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
endpackage

// File: rtl/btn_debounce.sv
// Raw active-low pushbutton to clean debounced level plus a one-cycle press
// pulse on each debounced 1->0 transition.
module btn_debounce
    import marquee_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw_n;
            sync2   <= sync1;
            level_d <= level;
            press   <= level_d & ~level;
            // Any return to the accepted level restarts the stability window
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/marquee_step_ctrl.sv
// Speed/pause control and tick counter producing the sequencer's single-cycle
// step enable from two debounced pushbuttons.
module marquee_step_ctrl
    import marquee_pkg::*;
#(
    parameter int BASE_PERIOD     = BASE_PERIOD_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_speed_n,
    input  logic               btn_pause_n,
    output logic               step,
    output logic [SPEED_W-1:0] speed,
    output logic               paused
);
    localparam int CW = $clog2(BASE_PERIOD);

    logic          speed_ev;
    logic          pause_ev;
    logic [1:0]    unused_levels;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed_btn (
        .clk   (clk),
        .reset (reset),
        .raw_n (btn_speed_n),
        .level (unused_levels[0]),
        .press (speed_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
        .clk   (clk),
        .reset (reset),
        .raw_n (btn_pause_n),
        .level (unused_levels[1]),
        .press (pause_ev)
    );

    always_comb begin
        last = CW'((BASE_PERIOD >> speed) - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step   <= 1'b0;
            speed  <= '0;
            paused <= 1'b0;
            cnt    <= '0;
        end else begin
            step <= 1'b0;
            if (speed_ev) begin
                speed <= speed + 1'b1;
            end
            if (pause_ev) begin
                paused <= ~paused;
            end
            // Clearing on every speed change keeps cnt within the new period
            if (speed_ev) begin
                cnt <= '0;
            end else if (!paused) begin
                if (cnt == last) begin
                    cnt  <= '0;
                    step <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_marquee_step_ctrl.sv
// Directed bench for marquee_step_ctrl with BASE_PERIOD=16, DEBOUNCE_CYCLES=4.
module tb_marquee_step_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_speed_n;
    logic       btn_pause_n;
    logic       step;
    logic [1:0] speed;
    logic       paused;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    marquee_step_ctrl #(
        .BASE_PERIOD     (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_speed_n (btn_speed_n),
        .btn_pause_n (btn_pause_n),
        .step        (step),
        .speed       (speed),
        .paused      (paused)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step must be high exactly at cycles first, first+per, ... (first=0: never)
    task automatic check_steps(input string tag, input int n, input int first, input int per);
        for (int i = 1; i <= n; i++) begin
            logic [31:0] e;
            tick();
            e = (first > 0 && i >= first && ((i - first) % per) == 0) ? 32'd1 : 32'd0;
            chk(tag, 32'(step), e);
        end
    endtask

    task automatic press_speed_clean();
        btn_speed_n = 1'b0;
        repeat (8) tick();
        btn_speed_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        reset       = 1'b1;
        btn_speed_n = 1'b1;
        btn_pause_n = 1'b1;
        repeat (3) tick();
        chk("rst_step", 32'(step), 0);
        chk("rst_speed", 32'(speed), 0);
        chk("rst_paused", 32'(paused), 0);
        reset = 1'b0;
        check_steps("base", 48, 16, 16);

        // First speed press: level flips at edge 6, speed updates at edge 8
        btn_speed_n = 1'b0;
        check_steps("sp_wait", 7, 0, 0);
        chk("sp_before", 32'(speed), 0);
        tick();
        chk("sp1", 32'(speed), 1);
        chk("sp1_step", 32'(step), 0);
        check_steps("sp1_hold", 2, 0, 0);
        btn_speed_n = 1'b1;
        check_steps("sp1_run", 22, 6, 8);

        press_speed_clean();
        chk("sp2", 32'(speed), 2);

        btn_speed_n = 1'b0;
        repeat (8) tick();
        chk("sp3", 32'(speed), 3);
        chk("sp3_step", 32'(step), 0);
        btn_speed_n = 1'b1;
        check_steps("sp3_run", 8, 2, 2);

        btn_speed_n = 1'b0;
        repeat (8) tick();
        chk("sp_wrap", 32'(speed), 0);
        btn_speed_n = 1'b1;
        check_steps("wrap_run", 16, 16, 16);

        // Bounce 0,1,0,1,0 then release: never stable long enough
        btn_pause_n = 1'b0; tick();
        btn_pause_n = 1'b1; tick();
        btn_pause_n = 1'b0; tick();
        btn_pause_n = 1'b1; tick();
        btn_pause_n = 1'b0; tick();
        btn_pause_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("bounce", 32'(paused), 0);
        end

        // Counter is 1 here; it reaches 9 on the pause edge and holds there
        btn_pause_n = 1'b0;
        check_steps("pz_wait", 7, 0, 0);
        tick();
        chk("pz_on", 32'(paused), 1);
        chk("pz_on_step", 32'(step), 0);
        btn_pause_n = 1'b1;
        check_steps("paused", 40, 0, 0);
        chk("pz_still", 32'(paused), 1);
        btn_pause_n = 1'b0;
        check_steps("pz2_wait", 7, 0, 0);
        tick();
        chk("pz_off", 32'(paused), 0);
        btn_pause_n = 1'b1;
        check_steps("resume", 23, 7, 16);

        // Simultaneous presses
        btn_speed_n = 1'b0;
        btn_pause_n = 1'b0;
        check_steps("both_wait", 7, 0, 0);
        tick();
        chk("both_speed", 32'(speed), 1);
        chk("both_paused", 32'(paused), 1);
        chk("both_step", 32'(step), 0);
        btn_speed_n = 1'b1;
        btn_pause_n = 1'b1;
        check_steps("both_hold", 20, 0, 0);
        chk("both_still", 32'(paused), 1);
        btn_pause_n = 1'b0;
        check_steps("unp_wait", 7, 0, 0);
        tick();
        chk("unp", 32'(paused), 0);
        btn_pause_n = 1'b1;
        check_steps("unp_run", 16, 8, 8);

        // Reset from a non-default state
        btn_pause_n = 1'b0;
        repeat (8) tick();
        chk("pre_rst_paused", 32'(paused), 1);
        btn_pause_n = 1'b1;
        reset = 1'b1;
        tick();
        chk("rst2_speed", 32'(speed), 0);
        chk("rst2_paused", 32'(paused), 0);
        chk("rst2_step", 32'(step), 0);
        reset = 1'b0;

        // Reset mid-debounce with counter at 10
        repeat (8) tick();
        btn_speed_n = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rst3_speed", 32'(speed), 0);
        chk("rst3_paused", 32'(paused), 0);
        chk("rst3_step", 32'(step), 0);
        reset = 1'b0;
        check_steps("rst_hold", 7, 0, 0);
        chk("rst_hold_speed", 32'(speed), 0);
        tick();
        chk("rst_hold_sp1", 32'(speed), 1);
        btn_speed_n = 1'b1;
        check_steps("post", 8, 8, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
